// File: rtl/lcd_capture.sv
// lcd_capture: writes the LCD pixel stream into a 160x144 framebuffer (addr = y*160+x).
// Define LCD_CAPTURE_BLANK_EN to blank the framebuffer with shade 0 while the LCD is off.
module lcd_capture (
    input  logic        clk,
    input  logic        reset,
    input  logic        lcd_clkena,
    input  logic [1:0]  lcd_data,
    input  logic [1:0]  lcd_mode,
    input  logic        lcd_on,
    output logic [14:0] fb_addr,
    output logic [1:0]  fb_data,
    output logic        fb_we,
    output logic        frame_done,
    output logic [1:0]  err
);
    localparam logic [14:0] FB_WORDS = 15'd23040;
`ifdef LCD_CAPTURE_BLANK_EN
    typedef enum logic [1:0] {OFF, ACTIVE, FILL} state_t;
    logic [14:0] fill_cnt, fill_nxt;
`else
    typedef enum logic [1:0] {OFF, ACTIVE} state_t;
`endif
    state_t      state, state_nxt;
    logic [7:0]  x, y, x_nxt, y_nxt;
    logic [14:0] line_base, base_nxt, addr_nxt;
    logic [1:0]  prev_mode, data_nxt, err_nxt;
    logic        prev_on, we_nxt, done_nxt;
    logic        rise, accept, line_end, frame_end;

    assign rise      = lcd_on & ~prev_on;
    assign accept    = lcd_clkena & lcd_on & (lcd_mode == 2'd3) & (state == ACTIVE);
    assign line_end  = (prev_mode == 2'd3) & (lcd_mode != 2'd3);
    assign frame_end = (lcd_mode == 2'd1) & (prev_mode != 2'd1);

    always_ff @(posedge clk) begin
        if (reset) state <= OFF;
        else       state <= state_nxt;
    end

`ifdef LCD_CAPTURE_BLANK_EN
    always_comb
        state_nxt = state == OFF    ? (rise ? ACTIVE : OFF) :
                    state == ACTIVE ? (lcd_on ? ACTIVE : FILL) :
                    rise ? ACTIVE : (fill_cnt == FB_WORDS ? OFF : FILL);
`else
    always_comb
        state_nxt = state == OFF ? (rise ? ACTIVE : OFF) : (lcd_on ? ACTIVE : OFF);
`endif

    always_comb begin
        x_nxt    = x;
        y_nxt    = y;
        base_nxt = line_base;
        addr_nxt = fb_addr;
        data_nxt = fb_data;
        we_nxt   = 1'b0;
        done_nxt = 1'b0;
        if (state != ACTIVE || !lcd_on) begin
            x_nxt    = 8'd0;
            y_nxt    = 8'd0;
            base_nxt = 15'd0;
        end else if (frame_end) begin
            x_nxt    = 8'd0;
            y_nxt    = 8'd0;
            base_nxt = 15'd0;
            done_nxt = 1'b1;
        end else begin
            if (accept && x < 8'd160) x_nxt = x + 8'd1;
            // base stops with y so it can never wrap past the buffer on runaway lines
            if (line_end) begin
                x_nxt    = 8'd0;
                y_nxt    = y < 8'd144 ? y + 8'd1 : y;
                base_nxt = y < 8'd144 ? line_base + 15'd160 : line_base;
            end
        end
        if (accept && x < 8'd160 && y < 8'd144) begin
            we_nxt   = 1'b1;
            addr_nxt = line_base + {7'd0, x};
            data_nxt = lcd_data;
        end
        err_nxt = err | {accept && y >= 8'd144, accept && x == 8'd160};
`ifdef LCD_CAPTURE_BLANK_EN
        fill_nxt = state != FILL ? 15'd0 : fill_cnt + {14'd0, fill_cnt != FB_WORDS};
        if (state == FILL && !lcd_on && fill_cnt != FB_WORDS) begin
            we_nxt   = 1'b1;
            addr_nxt = fill_cnt;
            data_nxt = 2'd0;
        end
        if (state == FILL && !lcd_on && fill_cnt == FB_WORDS) done_nxt = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= 8'd0;
            y          <= 8'd0;
            line_base  <= 15'd0;
            prev_mode  <= 2'd0;
            prev_on    <= 1'b0;
            fb_addr    <= 15'd0;
            fb_data    <= 2'd0;
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 2'b00;
`ifdef LCD_CAPTURE_BLANK_EN
            fill_cnt   <= 15'd0;
`endif
        end else begin
            x          <= x_nxt;
            y          <= y_nxt;
            line_base  <= base_nxt;
            prev_mode  <= lcd_mode;
            prev_on    <= lcd_on;
            fb_addr    <= addr_nxt;
            fb_data    <= data_nxt;
            fb_we      <= we_nxt;
            frame_done <= done_nxt;
            err        <= err_nxt;
`ifdef LCD_CAPTURE_BLANK_EN
            fill_cnt   <= fill_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture: directed stimulus against a pixel-coordinate model of lcd_capture,
// checked every cycle, plus literal checks of write counts, addresses and pulses.
module tb_lcd_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lcd_clkena = 1'b0;
    logic [1:0]  lcd_data = 2'd0;
    logic [1:0]  lcd_mode = 2'd0;
    logic        lcd_on = 1'b0;
    logic [14:0] fb_addr;
    logic [1:0]  fb_data;
    logic        fb_we;
    logic        frame_done;
    logic [1:0]  err;

    lcd_capture dut (
        .clk(clk), .reset(reset), .lcd_clkena(lcd_clkena), .lcd_data(lcd_data),
        .lcd_mode(lcd_mode), .lcd_on(lcd_on), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_we(fb_we), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int wr_cnt = 0, done_cnt = 0, first_addr = -1, last_addr = -1, last_data = -1;

    task automatic cmp(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // model state: 0 off, 1 capturing, 2 blanking
    int ms, mx, my, pm, pon, fillc, eaddr, edata;
    bit ew, ed;
    bit [1:0] eerr;

    always @(posedge clk) begin
        ew = 1'b0;
        ed = 1'b0;
        if (reset) begin
            ms = 0; mx = 0; my = 0; pm = 0; pon = 0; fillc = 0; eerr = 2'b00;
        end else begin
            if (ms == 0) begin
                if (lcd_on && !pon) begin ms = 1; mx = 0; my = 0; end
            end else if (ms == 1) begin
                if (!lcd_on) begin
                    mx = 0; my = 0; fillc = 0;
`ifdef LCD_CAPTURE_BLANK_EN
                    ms = 2;
`else
                    ms = 0;
`endif
                end else if (lcd_mode == 2'd1 && pm != 1) begin
                    ed = 1'b1; mx = 0; my = 0;
                end else begin
                    if (lcd_clkena && lcd_mode == 2'd3) begin
                        if (mx >= 160) eerr[0] = 1'b1;
                        if (my >= 144) eerr[1] = 1'b1;
                        if (mx < 160 && my < 144) begin
                            ew = 1'b1; eaddr = my * 160 + mx; edata = lcd_data;
                        end
                        if (mx < 160) mx++;
                    end
                    if (pm == 3 && lcd_mode != 2'd3) begin
                        mx = 0;
                        if (my < 144) my++;
                    end
                end
            end else begin
                if (lcd_on && !pon) begin ms = 1; mx = 0; my = 0; end
                else if (fillc < 23040) begin ew = 1'b1; eaddr = fillc; edata = 0; fillc++; end
                else begin ed = 1'b1; ms = 0; end
            end
            pm = lcd_mode;
            pon = lcd_on;
        end
        #1;
        cmp("fb_we", fb_we, ew);
        cmp("frame_done", frame_done, ed);
        cmp("err", err, eerr);
        if (ew) begin
            cmp("fb_addr", fb_addr, eaddr);
            cmp("fb_data", fb_data, edata);
        end
        if (fb_we) begin
            wr_cnt++;
            if (wr_cnt == 1) first_addr = fb_addr;
            last_addr = fb_addr;
            last_data = fb_data;
        end
        if (frame_done) done_cnt++;
    end

    task automatic drive(input bit on, input bit [1:0] mode, input bit ena, input bit [1:0] d);
        lcd_on = on; lcd_mode = mode; lcd_clkena = ena; lcd_data = d;
        @(negedge clk);
    endtask

    task automatic line(input int n);
        repeat (2) drive(1, 2'd2, 0, 2'd0);
        for (int i = 0; i < n; i++) begin
            if (n > 10 && i == n / 2) drive(1, 2'd3, 0, 2'd0);
            drive(1, 2'd3, 1, i[1:0]);
        end
        repeat (2) drive(1, 2'd0, 0, 2'd0);
    endtask

    task automatic vblank();
        repeat (3) drive(1, 2'd1, 0, 2'd0);
    endtask

    task automatic clr();
        wr_cnt = 0; done_cnt = 0; first_addr = -1; last_addr = -1; last_data = -1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        drive(1, 2'd0, 0, 2'd0);
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) drive(0, 2'd0, 0, 2'd0);
        reset = 1'b0;
        drive(0, 2'd0, 0, 2'd0);
        cmp("reset fb_we", fb_we, 0);
        cmp("reset fb_addr", fb_addr, 0);
        cmp("reset fb_data", fb_data, 0);
        cmp("reset frame_done", frame_done, 0);
        cmp("reset err", err, 0);

        // full frame
        drive(1, 2'd0, 0, 2'd0);
        clr();
        for (int l = 0; l < 144; l++) line(160);
        vblank();
        cmp("frame writes", wr_cnt, 23040);
        cmp("frame last addr", last_addr, 23039);
        cmp("frame last data", last_data, 3);
        cmp("frame done count", done_cnt, 1);
        cmp("frame err", err, 0);

        // overlong line 5
        pulse_reset();
        for (int l = 0; l < 5; l++) line(4);
        clr();
        line(162);
        cmp("long writes", wr_cnt, 160);
        cmp("long first addr", first_addr, 800);
        cmp("long last addr", last_addr, 959);
        cmp("long err", err, 1);
        clr();
        line(1);
        cmp("line6 addr", first_addr, 960);

        // last pixel immediately followed by mode-3 exit
        pulse_reset();
        clr();
        line(160);
        cmp("line0 last addr", last_addr, 159);
        cmp("line0 err cleared", err, 0);
        clr();
        line(1);
        cmp("line1 first addr", first_addr, 160);

        // 146 lines before vblank
        pulse_reset();
        clr();
        for (int l = 0; l < 143; l++) line(1);
        line(160);
        line(2);
        line(2);
        vblank();
        cmp("extra last addr", last_addr, 23039);
        cmp("extra writes", wr_cnt, 303);
        cmp("extra err", err, 2);
        cmp("extra done count", done_cnt, 1);

        // reset mid-line at line 40 pixel 20
        for (int l = 0; l < 40; l++) line(1);
        repeat (2) drive(1, 2'd2, 0, 2'd0);
        for (int i = 0; i < 20; i++) drive(1, 2'd3, 1, i[1:0]);
        reset = 1'b1;
        drive(1, 2'd3, 1, 2'd0);
        reset = 1'b0;
        cmp("midreset fb_we", fb_we, 0);
        cmp("midreset fb_addr", fb_addr, 0);
        cmp("midreset fb_data", fb_data, 0);
        cmp("midreset frame_done", frame_done, 0);
        cmp("midreset err", err, 0);

        // LCD off at line 70
        drive(1, 2'd0, 0, 2'd0);
        for (int l = 0; l < 70; l++) line(1);
        repeat (2) drive(1, 2'd2, 0, 2'd0);
        for (int i = 0; i < 10; i++) drive(1, 2'd3, 1, i[1:0]);
        clr();
`ifdef LCD_CAPTURE_BLANK_EN
        repeat (23045) drive(0, 2'd0, 0, 2'd0);
        cmp("fill writes", wr_cnt, 23040);
        cmp("fill first addr", first_addr, 0);
        cmp("fill last addr", last_addr, 23039);
        cmp("fill last data", last_data, 0);
        cmp("fill done count", done_cnt, 1);
        drive(1, 2'd0, 0, 2'd0);
        line(3);
        clr();
        for (int i = 0; i < 300 && wr_cnt < 100; i++) drive(0, 2'd0, 0, 2'd0);
        cmp("abort fill count", wr_cnt, 100);
        repeat (5) drive(1, 2'd0, 0, 2'd0);
        cmp("abort no more fill", wr_cnt, 100);
        cmp("abort no done", done_cnt, 0);
`else
        repeat (50) drive(0, 2'd0, 0, 2'd0);
        cmp("off writes", wr_cnt, 0);
        cmp("off done count", done_cnt, 0);
        drive(1, 2'd0, 0, 2'd0);
`endif
        clr();
        drive(1, 2'd3, 1, 2'd2);
        drive(1, 2'd0, 0, 2'd0);
        cmp("reenable addr", first_addr, 0);
        cmp("reenable data", last_data, 2);
        cmp("reenable writes", wr_cnt, 1);

        repeat (2) drive(1, 2'd0, 0, 2'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
